// File: rtl/tri_bus_pkg.sv
// Shared constants for the tri-state bus arbiter: FSM state encodings,
// default parameter values and a constant width helper.
package tri_bus_pkg;

  // FSM state encodings (2-bit, kept as plain constants for legacy tools)
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_OWN   = 2'd2;
  localparam logic [1:0] ST_TURN  = 2'd3;

  // Default build parameters
  localparam int DEF_N_REQ    = 4;
  localparam int DEF_TURN_CYC = 1;
  localparam int DEF_MAX_HOLD = 16;

  // Bits needed to index 'value' items; evaluated at elaboration time only.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/tri_bus_arbiter_rr_priority_pick.sv
// Combinational round-robin picker: scans the request vector starting at the
// rotating pointer and returns the first asserted requester as both a one-hot
// vector and an index, plus a flag telling whether anybody asked at all.
module rr_priority_pick
  import tri_bus_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IW    = clog2(DEF_N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_onehot,
  output logic [IW-1:0]    o_idx,
  output logic             o_any
);

  // One extra bit so ptr + offset cannot overflow before the wrap.
  localparam int CW = IW + 1;

  logic [CW-1:0] w_sum;
  logic [CW-1:0] w_cand;
  logic          w_hit;
  logic          w_found;

  // Walk the N_REQ candidates in rotated order; the first asserted one wins.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    w_found  = 1'b0;
    w_sum    = '0;
    w_cand   = '0;
    w_hit    = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      w_sum    = {1'b0, i_ptr} + CW'(k);
      w_cand   = (w_sum >= CW'(N_REQ)) ? (w_sum - CW'(N_REQ)) : w_sum;
      w_hit    = i_req[w_cand[IW-1:0]] & ~w_found;
      o_onehot[w_cand[IW-1:0]] = o_onehot[w_cand[IW-1:0]] | w_hit;
      o_idx    = w_hit ? w_cand[IW-1:0] : o_idx;
      w_found  = w_found | w_hit;
    end
    o_any = w_found;
  end

endmodule

// File: rtl/tri_bus_arbiter.sv
// Round-robin arbiter/sequencer for a shared tri-state data bus.
// Each ownership is framed as SETUP (grant only, drivers off) -> OWN (grant
// plus driver enable) -> TURN (everything off for TURN_CYC cycles) so that
// two drivers can never overlap and each driver gets enable recovery time.
// Every output comes straight from a flop; req_in only reaches the outputs
// through the next-state logic.
module tri_bus_arbiter
  import tri_bus_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int TURN_CYC = DEF_TURN_CYC,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [N_REQ-1:0]         req_in,
  output logic [N_REQ-1:0]         grant_out,
  output logic [N_REQ-1:0]         drv_en_out,
  output logic [clog2(N_REQ)-1:0]  owner_out,
  output logic                     busy_out,
  output logic                     preempt_out
);

  localparam int OW = clog2(N_REQ);

  localparam logic [7:0]    HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam logic [2:0]    TURN_LAST = 3'(TURN_CYC - 1);
  localparam logic [OW-1:0] IDX_LAST  = OW'(N_REQ - 1);

  // State and output registers
  logic [1:0]       r_state;
  logic [OW-1:0]    r_owner;
  logic [OW-1:0]    r_ptr;
  logic [7:0]       r_hold;
  logic [2:0]       r_turn;
  logic [N_REQ-1:0] r_grant;
  logic [N_REQ-1:0] r_drv;
  logic             r_busy;
  logic             r_preempt;

  // Next-state values
  logic [1:0]       w_state_nxt;
  logic [OW-1:0]    w_owner_nxt;
  logic [OW-1:0]    w_ptr_nxt;
  logic [7:0]       w_hold_nxt;
  logic [2:0]       w_turn_nxt;
  logic [N_REQ-1:0] w_grant_nxt;
  logic [N_REQ-1:0] w_drv_nxt;
  logic             w_busy_nxt;
  logic             w_preempt_nxt;

  // Arbitration and owner decode
  logic [N_REQ-1:0] w_pick_hot;
  logic [OW-1:0]    w_pick_idx;
  logic             w_pick_any;
  logic [N_REQ-1:0] w_owner_hot;
  logic             w_req_own;
  logic             w_req_other;
  logic [OW-1:0]    w_pick_after;

  rr_priority_pick #(
    .N_REQ (N_REQ),
    .IW    (OW)
  ) u_pick (
    .i_req    (req_in),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick_hot),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

  // Decode the registered owner and split requests into owner / everyone else.
  always_comb begin
    w_owner_hot          = '0;
    w_owner_hot[r_owner] = 1'b1;
    w_req_own            = |(req_in & w_owner_hot);
    w_req_other          = |(req_in & ~w_owner_hot);
    w_pick_after         = (w_pick_idx == IDX_LAST) ? '0 : (w_pick_idx + OW'(1));
  end

  // Sequencer: picks the next owner and computes every registered output.
  always_comb begin
    w_state_nxt   = r_state;
    w_owner_nxt   = r_owner;
    w_ptr_nxt     = r_ptr;
    w_hold_nxt    = r_hold;
    w_turn_nxt    = r_turn;
    w_grant_nxt   = '0;
    w_drv_nxt     = '0;
    w_busy_nxt    = 1'b0;
    w_preempt_nxt = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_pick_any) begin
          // The winner's successor becomes highest priority next time round.
          w_state_nxt = ST_SETUP;
          w_owner_nxt = w_pick_idx;
          w_ptr_nxt   = w_pick_after;
          w_grant_nxt = w_pick_hot;
          w_busy_nxt  = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_SETUP: begin
        if (w_req_own) begin
          w_state_nxt = ST_OWN;
          w_hold_nxt  = 8'd0;
          w_grant_nxt = w_owner_hot;
          w_drv_nxt   = w_owner_hot;
          w_busy_nxt  = 1'b1;
        end else begin
          // Request vanished before the driver was enabled: nothing to turn around.
          w_state_nxt = ST_IDLE;
        end
      end

      ST_OWN: begin
        if (!w_req_own) begin
          w_state_nxt = ST_TURN;
          w_turn_nxt  = 3'd0;
          w_busy_nxt  = 1'b1;
        end else if (r_hold == HOLD_LAST) begin
          if (w_req_other) begin
            w_state_nxt   = ST_TURN;
            w_turn_nxt    = 3'd0;
            w_busy_nxt    = 1'b1;
            w_preempt_nxt = 1'b1;
          end else begin
            // Nobody else is waiting: keep the bus and start a fresh hold window.
            w_hold_nxt  = 8'd0;
            w_grant_nxt = w_owner_hot;
            w_drv_nxt   = w_owner_hot;
            w_busy_nxt  = 1'b1;
          end
        end else begin
          w_hold_nxt  = r_hold + 8'd1;
          w_grant_nxt = w_owner_hot;
          w_drv_nxt   = w_owner_hot;
          w_busy_nxt  = 1'b1;
        end
      end

      ST_TURN: begin
        if (r_turn == TURN_LAST) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_turn_nxt  = r_turn + 3'd1;
          w_busy_nxt  = 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, counters and output flops; reset drops every enable on the same edge.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state   <= ST_IDLE;
      r_owner   <= '0;
      r_ptr     <= '0;
      r_hold    <= 8'd0;
      r_turn    <= 3'd0;
      r_grant   <= '0;
      r_drv     <= '0;
      r_busy    <= 1'b0;
      r_preempt <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_owner   <= w_owner_nxt;
      r_ptr     <= w_ptr_nxt;
      r_hold    <= w_hold_nxt;
      r_turn    <= w_turn_nxt;
      r_grant   <= w_grant_nxt;
      r_drv     <= w_drv_nxt;
      r_busy    <= w_busy_nxt;
      r_preempt <= w_preempt_nxt;
    end
  end

  assign grant_out   = r_grant;
  assign drv_en_out  = r_drv;
  assign owner_out   = r_owner;
  assign busy_out    = r_busy;
  assign preempt_out = r_preempt;

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Self-checking bench for tri_bus_arbiter (N_REQ=4, TURN_CYC=1, MAX_HOLD=16).
// Directed scenarios push the expected grantee into a scoreboard queue; a
// background monitor pops it whenever a new grant appears and also checks the
// bus-safety invariants every cycle.
module tb_tri_bus_arbiter;
  import tri_bus_pkg::*;

  localparam int N_REQ        = 4;
  localparam int TURN_CYC     = 1;
  localparam int MAX_HOLD     = 16;
  localparam int OW           = clog2(N_REQ);
  localparam int STARVE_LIMIT = 3 * (MAX_HOLD + 3);

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic [N_REQ-1:0] req_in;
  logic [N_REQ-1:0] grant_out;
  logic [N_REQ-1:0] drv_en_out;
  logic [OW-1:0]    owner_out;
  logic             busy_out;
  logic             preempt_out;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_q[$];
  logic sb_en   = 1'b0;

  always #5 clk_in = ~clk_in;

  tri_bus_arbiter #(
    .N_REQ    (N_REQ),
    .TURN_CYC (TURN_CYC),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .req_in      (req_in),
    .grant_out   (grant_out),
    .drv_en_out  (drv_en_out),
    .owner_out   (owner_out),
    .busy_out    (busy_out),
    .preempt_out (preempt_out)
  );

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic monitor_loop();
    logic [N_REQ-1:0] prev_drv;
    logic [N_REQ-1:0] prev_grant;
    logic [N_REQ-1:0] exp_hot;
    int               exp_idx;
    prev_drv   = '0;
    prev_grant = '0;
    forever begin
      @(negedge clk_in);
      assert (!$isunknown(req_in)) else $error("req_in carries X/Z");
      n_tests++;
      if (!$onehot0(drv_en_out)) begin
        n_fail++;
        $display("FAIL drv_onehot0: drv_en_out=%b, required one-hot or zero", drv_en_out);
      end
      n_tests++;
      if ((drv_en_out & ~grant_out) !== 4'b0000) begin
        n_fail++;
        $display("FAIL drv_implies_grant: drv_en_out=%b grant_out=%b", drv_en_out, grant_out);
      end
      n_tests++;
      if (prev_drv != 4'b0000 && drv_en_out != 4'b0000 && drv_en_out !== prev_drv) begin
        n_fail++;
        $display("FAIL drv_switch: drv_en_out went %b -> %b with no gap", prev_drv, drv_en_out);
      end
      if (sb_en && grant_out != 4'b0000 && prev_grant == 4'b0000) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: grant_out=%b, required no new grant", grant_out);
        end else begin
          exp_idx          = exp_q.pop_front();
          exp_hot          = '0;
          exp_hot[exp_idx] = 1'b1;
          if (grant_out !== exp_hot || owner_out !== OW'(exp_idx)) begin
            n_fail++;
            $display("FAIL sb_owner: grant_out=%b owner_out=%0d, required %b / %0d",
                     grant_out, owner_out, exp_hot, exp_idx);
          end
        end
      end
      prev_drv   = drv_en_out;
      prev_grant = grant_out;
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    req_in = 4'b0000;
    repeat (3) step();
    n_tests++;
    if ({grant_out, drv_en_out} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_enables: grant=%b drv=%b, required 0000/0000", grant_out, drv_en_out);
    end
    n_tests++;
    if ({owner_out, busy_out, preempt_out} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_status: owner=%0d busy=%b preempt=%b, required 0/0/0", owner_out, busy_out, preempt_out);
    end
    rst_in = 1'b0;
    step();
    n_tests++;
    if ({busy_out, grant_out} !== 5'b00000) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b grant=%b, required 0/0000", busy_out, grant_out);
    end
  endtask

  task automatic test_single_hold();
    exp_q.push_back(0);
    req_in = 4'b0001;
    step();
    n_tests++;
    if (grant_out !== 4'b0001 || drv_en_out !== 4'b0000 || busy_out !== 1'b1) begin
      n_fail++;
      $display("FAIL single_setup: grant=%b drv=%b busy=%b, required 0001/0000/1", grant_out, drv_en_out, busy_out);
    end
    step();
    n_tests++;
    if (grant_out !== 4'b0001 || drv_en_out !== 4'b0001) begin
      n_fail++;
      $display("FAIL single_own: grant=%b drv=%b, required 0001/0001", grant_out, drv_en_out);
    end
    for (int c = 0; c < 40; c++) begin
      step();
      n_tests++;
      if (drv_en_out !== 4'b0001 || preempt_out !== 1'b0) begin
        n_fail++;
        $display("FAIL single_held c%0d: drv=%b preempt=%b, required 0001/0", c, drv_en_out, preempt_out);
      end
    end
    req_in = 4'b0000;
    step();
    n_tests++;
    if (drv_en_out !== 4'b0000 || grant_out !== 4'b0000 || busy_out !== 1'b1) begin
      n_fail++;
      $display("FAIL single_release: drv=%b grant=%b busy=%b, required 0000/0000/1", drv_en_out, grant_out, busy_out);
    end
    step();
    n_tests++;
    if (busy_out !== 1'b0) begin
      n_fail++;
      $display("FAIL single_turn_len: busy=%b, required 0 after one TURN cycle", busy_out);
    end
  endtask

  task automatic test_round_robin();
    int               own_cnt[N_REQ];
    int               seen;
    int               zero_run;
    logic [N_REQ-1:0] prev_grant;
    rst_in = 1'b1;
    req_in = 4'b0000;
    step();
    rst_in = 1'b0;
    foreach (own_cnt[i]) own_cnt[i] = 0;
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(3);
    exp_q.push_back(0);
    seen       = 0;
    zero_run   = 0;
    prev_grant = '0;
    req_in     = 4'b1111;
    for (int cyc = 0; cyc < 300 && seen < 5; cyc++) begin
      step();
      if (grant_out == 4'b0000 && drv_en_out == 4'b0000) zero_run++;
      if (grant_out != 4'b0000 && prev_grant == 4'b0000) begin
        if (seen > 0) begin
          n_tests++;
          if (zero_run < 1) begin
            n_fail++;
            $display("FAIL rr_gap: %0d all-zero cycles before grant %b, required >= 1", zero_run, grant_out);
          end
        end
        seen++;
        zero_run = 0;
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (drv_en_out[i]) begin
          own_cnt[i]++;
          if (own_cnt[i] == 3) req_in[i] = 1'b0;
        end else if (!req_in[i] && !grant_out[i]) begin
          req_in[i]  = 1'b1;
          own_cnt[i] = 0;
        end
      end
      prev_grant = grant_out;
    end
    n_tests++;
    if (seen != 5) begin
      n_fail++;
      $display("FAIL rr_timeout: saw %0d grants, required 5", seen);
    end
    req_in = 4'b0000;
    repeat (4) step();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rr_pending: %0d expected grants never seen, required 0", exp_q.size());
    end
  endtask

  task automatic test_preempt();
    int own;
    int guard;
    exp_q.push_back(0);
    exp_q.push_back(2);
    req_in = 4'b0001;
    guard  = 0;
    while (drv_en_out !== 4'b0001 && guard < 10) begin
      step();
      guard++;
    end
    own   = (drv_en_out === 4'b0001) ? 1 : 0;
    guard = 0;
    while (preempt_out !== 1'b1 && guard < 60) begin
      if (own == 5) req_in = 4'b0101;
      step();
      guard++;
      if (drv_en_out === 4'b0001) own++;
    end
    n_tests++;
    if (preempt_out !== 1'b1 || own != 16) begin
      n_fail++;
      $display("FAIL preempt_point: preempt=%b after %0d OWN cycles, required 1 after 16", preempt_out, own);
    end
    n_tests++;
    if (grant_out !== 4'b0000 || drv_en_out !== 4'b0000) begin
      n_fail++;
      $display("FAIL preempt_turn: grant=%b drv=%b, required 0000/0000", grant_out, drv_en_out);
    end
    step();
    n_tests++;
    if (preempt_out !== 1'b0 || busy_out !== 1'b0) begin
      n_fail++;
      $display("FAIL preempt_pulse: preempt=%b busy=%b, required 0/0 (one TURN cycle)", preempt_out, busy_out);
    end
    step();
    n_tests++;
    if (grant_out !== 4'b0100 || owner_out !== 2'd2) begin
      n_fail++;
      $display("FAIL preempt_next: grant=%b owner=%0d, required 0100/2", grant_out, owner_out);
    end
    step();
    n_tests++;
    if (drv_en_out !== 4'b0100) begin
      n_fail++;
      $display("FAIL preempt_drive: drv=%b, required 0100", drv_en_out);
    end
    req_in = 4'b0000;
    repeat (4) step();
  endtask

  task automatic test_setup_abort();
    exp_q.push_back(1);
    req_in = 4'b0010;
    step();
    n_tests++;
    if (grant_out !== 4'b0010 || drv_en_out !== 4'b0000) begin
      n_fail++;
      $display("FAIL abort_setup: grant=%b drv=%b, required 0010/0000", grant_out, drv_en_out);
    end
    req_in = 4'b0000;
    step();
    n_tests++;
    if (grant_out !== 4'b0000 || busy_out !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: grant=%b busy=%b, required 0000/0 (no TURN)", grant_out, busy_out);
    end
    for (int c = 0; c < 5; c++) begin
      step();
      n_tests++;
      if (drv_en_out !== 4'b0000 || busy_out !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_quiet c%0d: drv=%b busy=%b, required 0000/0", c, drv_en_out, busy_out);
      end
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    exp_q.push_back(3);
    req_in = 4'b1000;
    guard  = 0;
    while (drv_en_out !== 4'b1000 && guard < 20) begin
      step();
      guard++;
    end
    n_tests++;
    if (drv_en_out !== 4'b1000) begin
      n_fail++;
      $display("FAIL rstmid_own: drv=%b, required 1000", drv_en_out);
    end
    step();
    rst_in = 1'b1;
    step();
    n_tests++;
    if ({grant_out, drv_en_out, owner_out, busy_out, preempt_out} !== 12'h000) begin
      n_fail++;
      $display("FAIL rstmid_clear: grant=%b drv=%b owner=%0d busy=%b preempt=%b, required all 0",
               grant_out, drv_en_out, owner_out, busy_out, preempt_out);
    end
    exp_q.push_back(0);
    rst_in = 1'b0;
    req_in = 4'b1001;
    step();
    n_tests++;
    if (grant_out !== 4'b0001 || owner_out !== 2'd0) begin
      n_fail++;
      $display("FAIL rstmid_regrant: grant=%b owner=%0d, required 0001/0", grant_out, owner_out);
    end
    step();
    n_tests++;
    if (drv_en_out !== 4'b0001) begin
      n_fail++;
      $display("FAIL rstmid_drive: drv=%b, required 0001", drv_en_out);
    end
    req_in = 4'b0000;
    repeat (4) step();
  endtask

  task automatic test_random();
    int   phase[N_REQ];
    int   wait_c[N_REQ];
    int   hold_c[N_REQ];
    int   zero_run;
    logic seen_any;
    sb_en    = 1'b0;
    req_in   = 4'b0000;
    zero_run = 0;
    seen_any = 1'b0;
    foreach (phase[i]) begin
      phase[i]  = 0;
      wait_c[i] = 0;
      hold_c[i] = 0;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      step();
      if (drv_en_out == 4'b0000) begin
        zero_run++;
      end else begin
        if (zero_run > 0 && seen_any) begin
          n_tests++;
          if (zero_run < TURN_CYC) begin
            n_fail++;
            $display("FAIL rand_gap: %0d idle cycles before drv %b, required >= %0d", zero_run, drv_en_out, TURN_CYC);
          end
        end
        zero_run = 0;
        seen_any = 1'b1;
      end
      for (int i = 0; i < N_REQ; i++) begin
        case (phase[i])
          0: begin
            if ($urandom_range(7, 0) == 0) begin
              req_in[i] = 1'b1;
              phase[i]  = 1;
              wait_c[i] = -1;
            end
          end
          1: begin
            if (grant_out[i]) begin
              n_tests++;
              if (wait_c[i] > STARVE_LIMIT) begin
                n_fail++;
                $display("FAIL rand_starve m%0d: waited %0d cycles, required <= %0d", i, wait_c[i], STARVE_LIMIT);
              end
              hold_c[i] = int'($urandom_range(24, 0));
              if (hold_c[i] == 0) begin
                req_in[i] = 1'b0;
                phase[i]  = 0;
              end else begin
                phase[i]  = 2;
              end
            end else begin
              wait_c[i]++;
            end
          end
          default: begin
            if (grant_out[i]) begin
              hold_c[i]--;
              if (hold_c[i] == 0) begin
                req_in[i] = 1'b0;
                phase[i]  = 0;
              end
            end else begin
              phase[i]  = 1;
              wait_c[i] = -1;
            end
          end
        endcase
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      n_tests++;
      if (phase[i] == 1 && wait_c[i] > STARVE_LIMIT) begin
        n_fail++;
        $display("FAIL rand_starve_end m%0d: waited %0d cycles, required <= %0d", i, wait_c[i], STARVE_LIMIT);
      end
    end
    req_in = 4'b0000;
    repeat (60) step();
    n_tests++;
    if (busy_out !== 1'b0 || grant_out !== 4'b0000) begin
      n_fail++;
      $display("FAIL rand_drain: busy=%b grant=%b, required 0/0000", busy_out, grant_out);
    end
  endtask

  initial begin
    rst_in = 1'b1;
    req_in = 4'b0000;
    test_reset();
    sb_en = 1'b1;
    fork
      monitor_loop();
    join_none
    test_single_hold();
    test_round_robin();
    test_preempt();
    test_setup_abort();
    test_reset_mid();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: %0d expected grants never seen, required 0", exp_q.size());
    end
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
